bus_arb_mux: RTL and testbench



---
 rtl/bus_arb_mux.sv | 136 +++++++++++++
 tb/tb_bus_arb_mux.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arb_mux.sv
// Registered bus arbiter/multiplexer with fixed-priority or round-robin grant and bus lock.
// Define BUS_ARB_CONFLICT_CNT_EN to implement the saturating conflict counter.
module bus_arb_mux #(
    parameter int NUM_SRC  = 24,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                      clock,
    input  logic                      clear_n,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_out,
    input  logic                      bus_lock,
    output logic [DATA_W-1:0]         bus_out,
    output logic [SEL_W-1:0]          select_out,
    output logic                      bus_valid,
    output logic                      conflict,
    output logic [7:0]                conflict_count
);

    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]   bus_q, bus_d;
    logic                valid_q, valid_d;
    logic                conf_q, conf_d;

    logic                any_req;
    logic                lock_hold;
    logic                rr_found;
    logic [SEL_W-1:0]    win_fp, win_rr, win, pick;
    logic [DATA_W-1:0]   pick_word;

    assign any_req = |src_out;
    assign conf_d  = (src_out & (src_out - 1'b1)) != '0;

    always_comb begin
        win_fp = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_out[i]) win_fp = SEL_W'(i);
        end
    end

    // Round-robin search begins just past the last winner and wraps.
    always_comb begin
        int j;
        j        = 0;
        win_rr   = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_SRC) j = j - NUM_SRC;
            if (!rr_found && src_out[j[SEL_W-1:0]]) begin
                win_rr   = j[SEL_W-1:0];
                rr_found = 1'b1;
            end
        end
    end

    assign win       = (ARB_MODE == 1) ? win_rr : win_fp;
    assign lock_hold = (state_q == LOCKED) && bus_lock && src_out[sel_q];
    assign pick      = lock_hold ? sel_q : win;

    always_comb begin
        pick_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pick == SEL_W'(i)) pick_word = src_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        bus_d    = '0;
        valid_d  = 1'b0;
        if (lock_hold) begin
            state_d = LOCKED;
            bus_d   = pick_word;
            valid_d = 1'b1;
        end else if (any_req) begin
            sel_d    = win;
            rr_ptr_d = win;
            bus_d    = pick_word;
            valid_d  = 1'b1;
            // A lock released this edge re-arbitrates without relocking.
            state_d  = (bus_lock && state_q != LOCKED) ? LOCKED : GRANT;
        end else begin
            state_d = IDLE;
        end
    end

`ifdef BUS_ARB_CONFLICT_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (conf_d && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign conflict_count = cnt_q;
`else
    assign conflict_count = '0;
`endif

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= SEL_W'(NUM_SRC - 1);
            bus_q    <= '0;
            valid_q  <= 1'b0;
            conf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            bus_q    <= bus_d;
            valid_q  <= valid_d;
            conf_q   <= conf_d;
        end
    end

    assign bus_out    = bus_q;
    assign select_out = sel_q;
    assign bus_valid  = valid_q;
    assign conflict   = conf_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Directed bench for bus_arb_mux: fixed-priority and round-robin instances on shared inputs.
module tb_bus_arb_mux;

    localparam int N = 24;
    localparam int W = 32;
    localparam int S = $clog2(N);
`ifdef BUS_ARB_CONFLICT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           clear_n;
    logic [N*W-1:0] src_data;
    logic [N-1:0]   src_out;
    logic           bus_lock;

    logic [W-1:0] fp_bus, rr_bus;
    logic [S-1:0] fp_sel, rr_sel;
    logic         fp_vld, rr_vld, fp_conf, rr_conf;
    logic [7:0]   fp_cnt, rr_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    bus_arb_mux #(.NUM_SRC(N), .DATA_W(W), .ARB_MODE(0)) u_fp (
        .clock(clock), .clear_n(clear_n), .src_data(src_data),
        .src_out(src_out), .bus_lock(bus_lock), .bus_out(fp_bus),
        .select_out(fp_sel), .bus_valid(fp_vld), .conflict(fp_conf),
        .conflict_count(fp_cnt)
    );

    bus_arb_mux #(.NUM_SRC(N), .DATA_W(W), .ARB_MODE(1)) u_rr (
        .clock(clock), .clear_n(clear_n), .src_data(src_data),
        .src_out(src_out), .bus_lock(bus_lock), .bus_out(rr_bus),
        .select_out(rr_sel), .bus_valid(rr_vld), .conflict(rr_conf),
        .conflict_count(rr_cnt)
    );

    typedef struct {
        logic [N-1:0] req;
        logic [W-1:0] bus;
        logic [S-1:0] sel;
        logic         vld;
        logic         conf;
        logic [7:0]   cnt;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [W-1:0] word(input int i);
        if (i == 21) return 32'hDEADBEEF;
        if (i == 0)  return 32'h12345678;
        return 32'hA000_0000 | i;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        #2 clear_n = 1'b0;
        #1 clear_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{24'h000000, 32'h0,        5'd0,  1'b0, 1'b0, 8'd0};
        tbl[1] = '{24'h200010, 32'hDEADBEEF, 5'd21, 1'b1, 1'b1, 8'd1};
        tbl[2] = '{24'h000080, 32'hA0000007, 5'd7,  1'b1, 1'b0, 8'd1};
        tbl[3] = '{24'h000000, 32'h0,        5'd7,  1'b0, 1'b0, 8'd1};
        tbl[4] = '{24'h000001, 32'h12345678, 5'd0,  1'b1, 1'b0, 8'd1};
        tbl[5] = '{24'h000000, 32'h0,        5'd0,  1'b0, 1'b0, 8'd1};
        tbl[6] = '{24'hFFFFFF, 32'hA0000017, 5'd23, 1'b1, 1'b1, 8'd2};
        tbl[7] = '{24'h000006, 32'hA0000002, 5'd2,  1'b1, 1'b1, 8'd3};

        for (int i = 0; i < N; i++) src_data[i*W +: W] = word(i);
        src_out  = '0;
        bus_lock = 1'b0;
        clear_n  = 1'b0;

        #3;
        chk("rst_bus", fp_bus, 0);
        chk("rst_sel", fp_sel, 0);
        chk("rst_vld", fp_vld, 0);
        chk("rst_cnt", fp_cnt, 0);
        @(negedge clock);
        clear_n = 1'b1;

        // Fixed-priority table
        for (int v = 0; v < 8; v++) begin
            src_out = tbl[v].req;
            step();
            chk($sformatf("fp_bus[%0d]", v), fp_bus, tbl[v].bus);
            chk($sformatf("fp_sel[%0d]", v), fp_sel, tbl[v].sel);
            chk($sformatf("fp_vld[%0d]", v), fp_vld, tbl[v].vld);
            chk($sformatf("fp_conf[%0d]", v), fp_conf, tbl[v].conf);
            chk($sformatf("fp_cnt[%0d]", v), fp_cnt, CNT_EN ? tbl[v].cnt : 8'd0);
        end
        src_out = '0;

        // Round-robin rotation 2,5,9,2
        do_reset();
        src_out = 24'h000224;
        begin
            int rr_exp [4];
            rr_exp = '{2, 5, 9, 2};
            for (int e = 0; e < 4; e++) begin
                step();
                chk($sformatf("rr_sel[%0d]", e), rr_sel, rr_exp[e]);
                chk($sformatf("rr_bus[%0d]", e), rr_bus, word(rr_exp[e]));
                chk($sformatf("rr_fp_sel[%0d]", e), fp_sel, 9);
            end
        end
        src_out = '0;
        step();
        chk("rr_idle_vld", rr_vld, 0);

        // Lock on R3 while R15 requests
        do_reset();
        src_out = 24'h000008;
        step();
        chk("lk_grant", fp_sel, 3);
        bus_lock = 1'b1;
        step();
        chk("lk_enter", fp_sel, 3);
        src_out = 24'h008008;
        for (int e = 0; e < 3; e++) begin
            if (e == 1) src_data[3*W +: W] = 32'h33333333;
            step();
            chk($sformatf("lk_fp_sel[%0d]", e), fp_sel, 3);
            chk($sformatf("lk_rr_sel[%0d]", e), rr_sel, 3);
            chk($sformatf("lk_conf[%0d]", e), fp_conf, 1);
        end
        chk("lk_track", fp_bus, 32'h33333333);
        src_out = 24'h008000;
        step();
        chk("lk_rel_fp", fp_sel, 15);
        chk("lk_rel_rr", rr_sel, 15);
        src_data[3*W +: W] = word(3);

        // Async reset mid-lock
        src_out = 24'h000008;
        step();
        step();
        chk("ar_pre", fp_vld, 1);
        #2 clear_n = 1'b0;
        #1;
        chk("ar_bus", fp_bus, 0);
        chk("ar_vld", fp_vld, 0);
        chk("ar_sel", fp_sel, 0);
        chk("ar_rr_vld", rr_vld, 0);
        chk("ar_conf", rr_conf, 0);
        #1 clear_n = 1'b1;
        bus_lock = 1'b0;
        src_out  = '1;
        step();
        chk("ar_rr_first", rr_sel, 0);
        chk("ar_rr_bus", rr_bus, 32'h12345678);
        chk("ar_fp_first", fp_sel, 23);

        // Conflict counter saturation
        src_out = '0;
        do_reset();
        src_out = 24'h000003;
        for (int e = 0; e < 300; e++) step();
        chk("sat_cnt_fp", fp_cnt, CNT_EN ? 8'd255 : 8'd0);
        chk("sat_cnt_rr", rr_cnt, CNT_EN ? 8'd255 : 8'd0);
        chk("sat_conf", fp_conf, 1);
        src_out = 24'h000001;
        step();
        chk("sat_conf_drop", fp_conf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
